// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared constants for the execute-stage ALU.
//
// Holds the datapath width and the 5-bit alucontrol operation codes that the
// instruction decoder emits (SIG_ALU_* / ALU_* names, same values as the
// decoder's define_alu_control.vh). Imported by the ALU interface and top.
package alu_exec_pkg;

    localparam int XLEN = 32;

    // alucontrol operation codes
    localparam logic [4:0] ALU_AND      = 5'd0;
    localparam logic [4:0] ALU_OR       = 5'd1;
    localparam logic [4:0] ALU_XOR      = 5'd2;
    localparam logic [4:0] ALU_NOR      = 5'd3;
    localparam logic [4:0] ALU_LUI      = 5'd4;
    localparam logic [4:0] ALU_SLL      = 5'd5;
    localparam logic [4:0] ALU_SRL      = 5'd6;
    localparam logic [4:0] ALU_SRA      = 5'd7;
    localparam logic [4:0] ALU_SLLV     = 5'd8;
    localparam logic [4:0] ALU_SRLV     = 5'd9;
    localparam logic [4:0] ALU_SRAV     = 5'd10;
    localparam logic [4:0] ALU_ADD      = 5'd11;
    localparam logic [4:0] ALU_ADDU     = 5'd12;
    localparam logic [4:0] ALU_SUB      = 5'd13;
    localparam logic [4:0] ALU_SUBU     = 5'd14;
    localparam logic [4:0] ALU_SLT      = 5'd15;
    localparam logic [4:0] ALU_SLTU     = 5'd16;
    localparam logic [4:0] ALU_MFHI     = 5'd17;
    localparam logic [4:0] ALU_MFLO     = 5'd18;
    localparam logic [4:0] ALU_MTHI     = 5'd19;
    localparam logic [4:0] ALU_MTLO     = 5'd20;
    localparam logic [4:0] SIG_ALU_FAIL = 5'd31;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operand / result bundle between the ID/EX latch, the ALU and
// the EX/MEM stage.
//
// Handshake: valid_i qualifies the operand fields in the cycle it is high.
// An op is taken on a rising edge where stall_i=0. While stall_i=1 the
// upstream holds its inputs and the ALU holds every output. flush_i kills
// both the op being captured and the op already in the result register.
// valid_o qualifies result_o/overflow_o/ri_o; hi_o/lo_o are always valid.
//
// Modports:
//   master - issuing side (drives operands/stall/flush, reads results)
//   slave  - the ALU
interface alu_exec_if;

    logic                            valid_i;
    logic [4:0]                      alucontrol_i;
    logic [alu_exec_pkg::XLEN-1:0]   srca_i;
    logic [alu_exec_pkg::XLEN-1:0]   srcb_i;
    logic [4:0]                      sa_i;
    logic                            stall_i;
    logic                            flush_i;
    logic                            valid_o;
    logic [alu_exec_pkg::XLEN-1:0]   result_o;
    logic                            overflow_o;
    logic                            ri_o;
    logic [alu_exec_pkg::XLEN-1:0]   hi_o;
    logic [alu_exec_pkg::XLEN-1:0]   lo_o;

    modport master (
        output valid_i, alucontrol_i, srca_i, srcb_i, sa_i, stall_i, flush_i,
        input  valid_o, result_o, overflow_o, ri_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, alucontrol_i, srca_i, srcb_i, sa_i, stall_i, flush_i,
        output valid_o, result_o, overflow_o, ri_o, hi_o, lo_o
    );

endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter shared by all six shift
// operations.
//
// Ports:
//   value_i    in  32  operand to shift
//   amount_i   in  5   shift distance
//   dir_left_i in  1   1 = shift left, 0 = shift right
//   arith_i    in  1   right shifts replicate the sign bit when set
//   result_o   out 32  shifted value
module alu_shifter (
    input  logic [31:0] value_i,
    input  logic [4:0]  amount_i,
    input  logic        dir_left_i,
    input  logic        arith_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = value_i;
        if (dir_left_i) begin
            result_o = value_i << amount_i;
        end else if (arith_i) begin
            result_o = $unsigned($signed(value_i) >>> amount_i);
        end else begin
            result_o = value_i >> amount_i;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a registered result and the HI/LO pair.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   alu_exec_if.slave: valid_i, alucontrol_i, srca_i, srcb_i, sa_i,
//         stall_i, flush_i in; valid_o, result_o, overflow_o, ri_o, hi_o,
//         lo_o out
//
// One-cycle latency, one op per cycle. HI/LO are written on the capture
// edge, so an MFHI/MFLO issued the next cycle reads the new value directly.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);

    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sum_w, diff_w, sh_result;
    logic [4:0]       sh_amount;
    logic             sh_left, sh_arith, sh_var;
    logic             add_ovf, sub_ovf, slt_s, slt_u;

    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;
    logic             ri_d, ri_q;
    logic             valid_q;
    logic             hi_we, lo_we, commit;
    logic [WIDTH-1:0] hi_q, lo_q;

    assign a = bus.srca_i;
    assign b = bus.srcb_i;

    assign sum_w  = a + b;
    assign diff_w = a - b;
    // Signed overflow: operands agree in sign (add) / differ (sub) and the
    // result sign departs from a.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
    assign slt_s   = $signed(a) < $signed(b);
    assign slt_u   = a < b;

    // Variable shifts take the distance from rs; fixed shifts from sa.
    assign sh_var    = (bus.alucontrol_i == ALU_SLLV) || (bus.alucontrol_i == ALU_SRLV) ||
                       (bus.alucontrol_i == ALU_SRAV);
    assign sh_amount = sh_var ? a[4:0] : bus.sa_i;
    assign sh_left   = (bus.alucontrol_i == ALU_SLL) || (bus.alucontrol_i == ALU_SLLV);
    assign sh_arith  = (bus.alucontrol_i == ALU_SRA) || (bus.alucontrol_i == ALU_SRAV);

    alu_shifter u_shifter (
        .value_i    (b),
        .amount_i   (sh_amount),
        .dir_left_i (sh_left),
        .arith_i    (sh_arith),
        .result_o   (sh_result)
    );

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        ri_d       = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        case (bus.alucontrol_i)
            ALU_AND:  result_d = a & b;
            ALU_OR:   result_d = a | b;
            ALU_XOR:  result_d = a ^ b;
            ALU_NOR:  result_d = ~(a | b);
            ALU_LUI:  result_d = {b[15:0], 16'h0000};
            ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_SLLV, ALU_SRLV, ALU_SRAV:
                      result_d = sh_result;
            ALU_ADD: begin
                result_d   = sum_w;
                overflow_d = add_ovf;
            end
            ALU_ADDU: result_d = sum_w;
            ALU_SUB: begin
                result_d   = diff_w;
                overflow_d = sub_ovf;
            end
            ALU_SUBU: result_d = diff_w;
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, slt_u};
            ALU_MFHI: result_d = hi_q;
            ALU_MFLO: result_d = lo_q;
            ALU_MTHI: hi_we = 1'b1;
            ALU_MTLO: lo_we = 1'b1;
            default:  ri_d = 1'b1;   // SIG_ALU_FAIL and any unassigned code
        endcase
    end

    // HI/LO only change for a live op that actually leaves this stage.
    assign commit = bus.valid_i & ~bus.stall_i & ~bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            ri_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // Flush wins over stall for the qualifier and flags.
            if (bus.flush_i) begin
                valid_q    <= 1'b0;
                overflow_q <= 1'b0;
                ri_q       <= 1'b0;
            end else if (!bus.stall_i) begin
                valid_q    <= bus.valid_i;
                overflow_q <= overflow_d;
                ri_q       <= ri_d;
            end
            if (!bus.stall_i) begin
                result_q <= result_d;
            end
            if (commit && hi_we) begin
                hi_q <= a;
            end
            if (commit && lo_we) begin
                lo_q <= a;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.result_o   = result_q;
    assign bus.overflow_o = overflow_q;
    assign bus.ri_o       = ri_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_exec_if bus ();

    alu_exec #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then advance to 1 ns
    // past the next rising edge so outputs are settled for checking.
    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa, input logic st,
                         input logic fl, input logic rs);
        @(negedge clk);
        bus.valid_i      = v;
        bus.alucontrol_i = op;
        bus.srca_i       = a;
        bus.srcb_i       = b;
        bus.sa_i         = sa;
        bus.stall_i      = st;
        bus.flush_i      = fl;
        rst              = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [4:0] code, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sa);
        drive(1'b1, code, a, b, sa, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Check the qualified result triple.
    task automatic chk_res(input string tag, input logic [31:0] exp_res,
                           input logic exp_ovf);
        chk({tag, ".valid"}, {31'b0, bus.valid_o}, 32'd1);
        chk({tag, ".result"}, bus.result_o, exp_res);
        chk({tag, ".ovf"}, {31'b0, bus.overflow_o}, {31'b0, exp_ovf});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus.valid_i      = 1'b0;
        bus.alucontrol_i = ALU_AND;
        bus.srca_i       = '0;
        bus.srcb_i       = '0;
        bus.sa_i         = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;

        // Reset state
        drive(1'b0, ALU_AND, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, ALU_AND, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("rst.valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst.result", bus.result_o, 32'h0);
        chk("rst.ovf", {31'b0, bus.overflow_o}, 32'd0);
        chk("rst.ri", {31'b0, bus.ri_o}, 32'd0);
        chk("rst.hi", bus.hi_o, 32'h0);
        chk("rst.lo", bus.lo_o, 32'h0);

        // Arithmetic and overflow
        op(ALU_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0); chk_res("add",  32'h8000_0000, 1'b1);
        op(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0); chk_res("addu", 32'h8000_0000, 1'b0);
        op(ALU_SUB,  32'h8000_0000, 32'h1, 5'd0); chk_res("sub",  32'h7FFF_FFFF, 1'b1);
        op(ALU_SUBU, 32'h0,         32'h1, 5'd0); chk_res("subu", 32'hFFFF_FFFF, 1'b0);
        op(ALU_ADD,  32'h5,         32'h3, 5'd0); chk_res("add_small", 32'h8, 1'b0);

        // Shifts
        op(ALU_SRA,  32'h0,  32'h8000_0000, 5'd4);  chk_res("sra4",   32'hF800_0000, 1'b0);
        op(ALU_SRAV, 32'h24, 32'h8000_0000, 5'd0);  chk_res("srav",   32'hF800_0000, 1'b0);
        op(ALU_SRL,  32'h0,  32'h8000_0000, 5'd4);  chk_res("srl4",   32'h0800_0000, 1'b0);
        op(ALU_SLL,  32'h0,  32'h0000_1234, 5'd0);  chk_res("sll0",   32'h0000_1234, 1'b0);
        op(ALU_SRA,  32'h0,  32'h8000_0001, 5'd31); chk_res("sra31",  32'hFFFF_FFFF, 1'b0);
        op(ALU_SLLV, 32'h3,  32'h1,         5'd9);  chk_res("sllv",   32'h8, 1'b0);
        op(ALU_SRLV, 32'h21, 32'h8000_0000, 5'd0);  chk_res("srlv",   32'h4000_0000, 1'b0);

        // Compares
        op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0); chk_res("sltu", 32'h0, 1'b0);
        op(ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0); chk_res("slt",  32'h1, 1'b0);

        // Logic
        op(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0); chk_res("and", 32'h00F0_000F, 1'b0);
        op(ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0); chk_res("or",  32'hFFF0_0FFF, 1'b0);
        op(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0); chk_res("xor", 32'hFF00_0FF0, 1'b0);
        op(ALU_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0); chk_res("nor", 32'h000F_F000, 1'b0);

        // Flushed MTHI leaves HI untouched
        drive(1'b1, ALU_MTHI, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mthi_flush.hi", bus.hi_o, 32'h0);
        chk("mthi_flush.valid", {31'b0, bus.valid_o}, 32'd0);

        // MTHI then MFHI back-to-back
        op(ALU_MTHI, 32'h1234_5678, 32'h0, 5'd0);
        chk_res("mthi", 32'h0, 1'b0);
        chk("mthi.hi", bus.hi_o, 32'h1234_5678);
        op(ALU_MFHI, 32'h0, 32'h0, 5'd0);
        chk_res("mfhi", 32'h1234_5678, 1'b0);

        // LUI then hold under stall; stalled inputs are a live MTHI
        op(ALU_LUI, 32'h0, 32'h0000_ABCD, 5'd0);
        chk_res("lui", 32'hABCD_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ALU_MTHI, 32'h0000_FFFF, 32'h1, 5'd0, 1'b1, 1'b0, 1'b0);
            chk_res("stall", 32'hABCD_0000, 1'b0);
            chk("stall.hi", bus.hi_o, 32'h1234_5678);
        end
        drive(1'b1, ALU_ADD, 32'h1, 32'h1, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("stall_flush.valid", {31'b0, bus.valid_o}, 32'd0);

        // Reserved-instruction reporting
        op(SIG_ALU_FAIL, 32'h5, 32'h7, 5'd0);
        chk_res("fail", 32'h0, 1'b0);
        chk("fail.ri", {31'b0, bus.ri_o}, 32'd1);
        op(5'd26, 32'h5, 32'h7, 5'd0);
        chk("unlisted.ri", {31'b0, bus.ri_o}, 32'd1);
        chk("unlisted.result", bus.result_o, 32'h0);

        // Bubble: no live op
        drive(1'b0, ALU_ADD, 32'h1, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("bubble.valid", {31'b0, bus.valid_o}, 32'd0);

        // MTLO, then reset clears everything
        op(ALU_MTLO, 32'h5, 32'h0, 5'd0);
        chk("mtlo.lo", bus.lo_o, 32'h5);
        op(SIG_ALU_FAIL, 32'h0, 32'h0, 5'd0);
        chk("prerst.ri", {31'b0, bus.ri_o}, 32'd1);
        drive(1'b1, ALU_MTHI, 32'h9999_9999, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("postrst.lo", bus.lo_o, 32'h0);
        chk("postrst.hi", bus.hi_o, 32'h0);
        chk("postrst.valid", {31'b0, bus.valid_o}, 32'd0);
        chk("postrst.ri", {31'b0, bus.ri_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
